hdpldadapt_cmn_cp_dist_pipe: RTL

HDPLDADAPT_CMN_CP_DIST_PIPE -- requirements
Module: hdpldadapt_cmn_cp_dist_pipe

---
 rtl/hdpldadapt_cmn_cp_dist_pipe.sv | 109 ++++++++++
 1 files changed

// File: rtl/hdpldadapt_cmn_cp_dist_pipe.sv
// Control-word distribution stage: sources or forwards a control value through a selectable-depth pipeline.
// Optional stability counter is built only when HDPLDADAPT_CMN_CP_DIST_STABLE_EN is defined.
module hdpldadapt_cmn_cp_dist_pipe #(
  parameter int unsigned WIDTH      = 1,
  parameter int unsigned DEPTH      = 4,
  parameter logic        RESET_VAL  = 1'b0,
  parameter int unsigned STABLE_CNT = 8,
  localparam int unsigned DW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             data_enable,
  input  logic [WIDTH-1:0] master_in,
  input  logic [WIDTH-1:0] dist_in,
  input  logic             r_dist_master,
  input  logic [DW-1:0]    r_dist_depth,
  output logic [WIDTH-1:0] dist_out,
  output logic [WIDTH-1:0] dist_tap,
  output logic             dist_change,
  output logic             dist_stable
);

  localparam logic [WIDTH-1:0] RST_WORD = {WIDTH{RESET_VAL}};

  if (WIDTH == 0 || WIDTH > 64) begin : g_bad_width
    $error("WIDTH must be in 1..64");
  end
  if (DEPTH == 0 || DEPTH > 8) begin : g_bad_depth
    $error("DEPTH must be in 1..8");
  end
  if (STABLE_CNT == 0 || STABLE_CNT > 255) begin : g_bad_stable_cnt
    $error("STABLE_CNT must be in 1..255");
  end

  logic [WIDTH-1:0]              src_c;
  logic [DW-1:0]                 depth_c;
  logic [DEPTH-1:0][WIDTH-1:0]   pipe_q, pipe_d;
  logic [DEPTH:0][WIDTH-1:0]     stage_c;
  logic [WIDTH-1:0]              tap_q, tap_d;
  logic [WIDTH-1:0]              prev_q;
  logic                          change_q, change_d;

  assign src_c   = r_dist_master ? master_in : dist_in;
  assign depth_c = (r_dist_depth > DW'(DEPTH)) ? DW'(DEPTH) : r_dist_depth;

  // stage_c[0] is the live source, stage_c[k] is pipeline stage k
  assign stage_c  = {pipe_q, src_c};
  assign dist_out = stage_c[depth_c];
  assign dist_tap = (depth_c == '0) ? dist_in : tap_q;
  assign change_d = (dist_out != prev_q);

  always_comb begin
    pipe_d = pipe_q;
    tap_d  = tap_q;
    if (data_enable) begin
      pipe_d = stage_c[DEPTH-1:0];
      tap_d  = dist_in;
    end
  end

  // prev_q tracks dist_out every clock so CRAM-induced switches also register as changes
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      pipe_q   <= {DEPTH{RST_WORD}};
      tap_q    <= RST_WORD;
      prev_q   <= RST_WORD;
      change_q <= 1'b0;
    end else begin
      pipe_q   <= pipe_d;
      tap_q    <= tap_d;
      prev_q   <= dist_out;
      change_q <= change_d;
    end
  end

  assign dist_change = change_q;

`ifdef HDPLDADAPT_CMN_CP_DIST_STABLE_EN
  localparam int unsigned CW = $clog2(STABLE_CNT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q;

  // a change clears the count even on an enabled cycle
  always_comb begin
    cnt_d = cnt_q;
    if (change_d) begin
      cnt_d = '0;
    end else if (data_enable && (cnt_q != CW'(STABLE_CNT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= (cnt_d == CW'(STABLE_CNT));
    end
  end

  assign dist_stable = stable_q;
`else
  assign dist_stable = 1'b0;
`endif

endmodule
